// File: rtl/perf_mon_pkg.sv
// Shared types and default constants for the perf_monitor block.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int          CNT_W_DEF         = 32;
  localparam logic [31:0] PASS_ADDR_DEF     = 32'd100;
  localparam logic [31:0] PASS_DATA_DEF     = 32'd25;
  localparam logic [31:0] IGNORE_ADDR_DEF   = 32'd96;
  localparam logic [31:0] TIMEOUT_FAIL_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/perf_monitor_sat_counter.sv
// Saturating up-counter; holds at all-ones and stops while frozen.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         freeze,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en && !freeze && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Performance counters and pass/fail signature checker tapping the pipeline W/M stages.
// Optional watchdog timeout is compiled in with `define PERF_MON_TIMEOUT_EN.
//
//   state  | meaning
//   WARMUP | post-reset settling, inputs ignored, nothing counted
//   RUN    | counting, watching memory writes for the signature
//   DONE   | terminal result latched, counters frozen until reset
module perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int          CNT_W          = CNT_W_DEF,
  parameter logic [31:0] PASS_ADDR      = PASS_ADDR_DEF,
  parameter logic [31:0] PASS_DATA      = PASS_DATA_DEF,
  parameter logic [31:0] IGNORE_ADDR    = IGNORE_ADDR_DEF,
  parameter int          WARMUP_CYCLES  = 2,
  parameter int          TIMEOUT_CYCLES = 10000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ValidW,
  input  logic             StallF,
  input  logic             FlushE,
  input  logic             MemWriteM,
  input  logic [31:0]      DataAdrM,
  input  logic [31:0]      WriteDataM,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [31:0]      fail_addr,
  output logic [31:0]      fail_data
);

  state_t      state_q, state_d;
  logic [31:0] warm_q, warm_d;
  logic        pass_d, fail_d;
  logic [31:0] fail_addr_d, fail_data_d;
  logic        pass_hit, fail_hit;
  logic        freeze;

  assign freeze = (state_q != RUN);

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk(clk), .reset_n(reset_n), .en(1'b1), .freeze(freeze), .count(cycle_count)
  );
  sat_counter #(.W(CNT_W)) u_instr (
    .clk(clk), .reset_n(reset_n), .en(ValidW), .freeze(freeze), .count(instr_retired)
  );
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .reset_n(reset_n), .en(StallF), .freeze(freeze), .count(stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .reset_n(reset_n), .en(FlushE), .freeze(freeze), .count(flush_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= (WARMUP_CYCLES == 0) ? RUN : WARMUP;
      warm_q    <= 32'(WARMUP_CYCLES);
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      pass      <= pass_d;
      fail      <= fail_d;
      fail_addr <= fail_addr_d;
      fail_data <= fail_data_d;
    end
  end

  assign done = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    pass_d      = pass;
    fail_d      = fail;
    fail_addr_d = fail_addr;
    fail_data_d = fail_data;
    pass_hit    = MemWriteM && (DataAdrM == PASS_ADDR) && (WriteDataM == PASS_DATA);
    fail_hit    = MemWriteM && (DataAdrM != IGNORE_ADDR) && !pass_hit;

    case (state_q)
      WARMUP: begin
        if (warm_q <= 32'd1) begin
          state_d = RUN;
          warm_d  = '0;
        end else begin
          warm_d = warm_q - 32'd1;
        end
      end
      RUN: begin
        if (pass_hit) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else if (fail_hit) begin
          state_d     = DONE;
          fail_d      = 1'b1;
          fail_addr_d = DataAdrM;
          fail_data_d = WriteDataM;
        end
`ifdef PERF_MON_TIMEOUT_EN
        // fail_data reports the count as it stands after this terminating edge
        else if (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = DONE;
          fail_d      = 1'b1;
          fail_addr_d = TIMEOUT_FAIL_ADDR;
          fail_data_d = 32'(TIMEOUT_CYCLES);
        end
`endif
      end
      DONE: ;
      default: state_d = DONE;
    endcase
  end

`ifndef PERF_MON_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor with a queue of expected terminal results.
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ValidW, StallF, FlushE, MemWriteM;
  logic [31:0] DataAdrM, WriteDataM;
  logic [31:0] cycle_count, instr_retired, stall_cycles, flush_count;
  logic        done, pass, fail;
  logic [31:0] fail_addr, fail_data;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic        d, p, f;
    logic [31:0] fa, fd, cyc, ins, stl, fl;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  perf_monitor #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n),
    .ValidW(ValidW), .StallF(StallF), .FlushE(FlushE),
    .MemWriteM(MemWriteM), .DataAdrM(DataAdrM), .WriteDataM(WriteDataM),
    .cycle_count(cycle_count), .instr_retired(instr_retired),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .done(done), .pass(pass), .fail(fail),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic f,
                      input logic mw, input logic [31:0] a, input logic [31:0] d);
    ValidW = v; StallF = s; FlushE = f; MemWriteM = mw; DataAdrM = a; WriteDataM = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic zero_inputs();
    ValidW = 0; StallF = 0; FlushE = 0; MemWriteM = 0; DataAdrM = 0; WriteDataM = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc"},   cycle_count,   32'd0);
    check({tag, "_ins"},   instr_retired, 32'd0);
    check({tag, "_stl"},   stall_cycles,  32'd0);
    check({tag, "_fl"},    flush_count,   32'd0);
    check({tag, "_flags"}, {29'd0, done, pass, fail}, 32'd0);
    check({tag, "_faddr"}, fail_addr,     32'd0);
    check({tag, "_fdata"}, fail_data,     32'd0);
  endtask

  // Called between edges; checks the asynchronous clear, then releases 3 ns before an edge.
  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    zero_inputs();
    #1;
    check_all_zero(tag);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic push_exp(input string tag, input logic p, input logic f,
                          input logic [31:0] fa, input logic [31:0] fd,
                          input logic [31:0] cyc, input logic [31:0] ins,
                          input logic [31:0] stl, input logic [31:0] fl);
    exp_t e;
    e.tag = tag; e.d = 1'b1; e.p = p; e.f = f; e.fa = fa; e.fd = fd;
    e.cyc = cyc; e.ins = ins; e.stl = stl; e.fl = fl;
    sb.push_back(e);
  endtask

  task automatic expect_done(input int budget);
    exp_t e;
    int   n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_done"},  {31'd0, done}, {31'd0, e.d});
    check({e.tag, "_pass"},  {31'd0, pass}, {31'd0, e.p});
    check({e.tag, "_fail"},  {31'd0, fail}, {31'd0, e.f});
    check({e.tag, "_faddr"}, fail_addr,     e.fa);
    check({e.tag, "_fdata"}, fail_data,     e.fd);
    check({e.tag, "_cyc"},   cycle_count,   e.cyc);
    check({e.tag, "_ins"},   instr_retired, e.ins);
    check({e.tag, "_stl"},   stall_cycles,  e.stl);
    check({e.tag, "_fl"},    flush_count,   e.fl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench watchdog");
  end

  initial begin
    // T1: reset release at 22 ns, ValidW every cycle, signature on RUN cycle 30
    reset_n = 1'b0;
    zero_inputs();
    #2;
    check_all_zero("t1_rst");
    #20 reset_n = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("t1_warm_cyc", cycle_count, 32'd0);
    for (int c = 1; c <= 29; c++) step(1, 0, 0, 0, 0, 0);
    check("t1_pre_done", {31'd0, done}, 32'd0);
    push_exp("t1", 1, 0, 0, 0, 30, 30, 0, 0);
    step(1, 0, 0, 1, 32'd100, 32'd25);
    expect_done(4);

    // T2: mixed ValidW/StallF/FlushE then pass
    apply_reset("t2_rst");
    idle(2);
    for (int c = 1; c <= 30; c++) begin
      logic v, s, f, w;
      v = !(c == 3 || c == 7 || c == 11 || c == 15 || c == 19);
      s = (c >= 4 && c <= 6);
      f = (c == 20 || c == 21);
      w = (c == 30);
      if (w) push_exp("t2", 1, 0, 0, 0, 30, 25, 3, 2);
      step(v, s, f, w, w ? 32'd100 : 32'd0, w ? 32'd25 : 32'd0);
    end
    expect_done(4);

    // T3: ignored write on cycle 10, failing write on cycle 12
    apply_reset("t3_rst");
    idle(2);
    for (int c = 1; c <= 12; c++) begin
      if (c == 10)      step(1, 0, 0, 1, 32'd96, 32'd7);
      else if (c == 12) begin
        push_exp("t3", 0, 1, 32'd104, 32'd9, 12, 12, 0, 0);
        step(1, 0, 0, 1, 32'd104, 32'd9);
      end
      else              step(1, 0, 0, 0, 0, 0);
      if (c == 10) check("t3_ignore_done", {31'd0, done}, 32'd0);
    end
    expect_done(4);

    // T4: signature write during warmup is ignored
    apply_reset("t4_rst");
    step(1, 1, 1, 1, 32'd100, 32'd25);
    check("t4_w1_done", {31'd0, done}, 32'd0);
    check("t4_w1_cyc",  cycle_count,   32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("t4_w2_cyc",  cycle_count,   32'd0);
    check("t4_w2_ins",  instr_retired, 32'd0);
    idle(20);
    check("t4_run_cyc",  cycle_count,   32'd20);
    check("t4_run_done", {31'd0, done}, 32'd0);

    // T5: counters frozen after pass, then async reset clears everything
    apply_reset("t5_rst");
    idle(2);
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        push_exp("t5", 1, 0, 0, 0, 5, 5, 1, 0);
        step(1, 0, 0, 1, 32'd100, 32'd25);
      end else step(1, (c == 2), 0, 0, 0, 0);
    end
    expect_done(4);
    for (int c = 0; c < 50; c++)
      step(1, 1, 1, 1, (c % 2 == 0) ? 32'd200 : 32'd100, 32'(c));
    check("t5_frz_cyc",   cycle_count,   32'd5);
    check("t5_frz_ins",   instr_retired, 32'd5);
    check("t5_frz_stl",   stall_cycles,  32'd1);
    check("t5_frz_fl",    flush_count,   32'd0);
    check("t5_frz_flags", {29'd0, done, pass, fail}, 32'b110);
    check("t5_frz_faddr", fail_addr,     32'd0);
    apply_reset("t5_async");

`ifdef PERF_MON_TIMEOUT_EN
    // T6: watchdog fires at cycle_count 100
    idle(2);
    idle(99);
    check("t6_pre_done", {31'd0, done}, 32'd0);
    push_exp("t6", 0, 1, 32'hFFFF_FFFF, 32'd100, 100, 0, 0, 0);
    idle(1);
    expect_done(4);
`else
    // T6: without the watchdog the monitor keeps running
    idle(2);
    idle(150);
    check("t6_no_to_done", {31'd0, done}, 32'd0);
    check("t6_no_to_cyc",  cycle_count,   32'd150);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
